// File: rtl/function_checker.sv
`default_nettype none
// ============================================================================
//  Module      : function_checker
//  Description : Exhaustive checker for a 4-input combinational function.
//                Walks the 16 input vectors on {a,b,c,d}, holds each for
//                SETTLE_CYCLES cycles, samples f and compares it against the
//                golden truth table EXPECTED. Reports the mismatch count and
//                the index of the first failing vector.
//                Optional build macro FUNCTION_CHECKER_FAIL_STOP_EN ends the
//                run at the first mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module function_checker #(
    parameter logic [15:0] EXPECTED      = 16'hF888,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       fail_valid
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_last_index  = 4'd15;
    localparam logic [4:0] c_err_max     = 5'd16;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_index;
    logic [3:0] r_settle_cnt;
    logic [4:0] r_err_count;
    logic [3:0] r_first_fail;
    logic       r_fail_valid;

    logic       w_start_ok;
    logic       w_settle_end;
    logic       w_mismatch;

    // start is only honoured when no run is in flight
    assign w_start_ok   = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_settle_end = (r_settle_cnt == c_settle_last);
    assign w_mismatch   = (f != EXPECTED[r_index]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) w_next_state = c_st_settle;
            end
            c_st_settle: begin
                if (w_settle_end) w_next_state = c_st_sample;
            end
            c_st_sample: begin
                if (r_index == c_last_index) begin
                    w_next_state = c_st_done;
                end
`ifdef FUNCTION_CHECKER_FAIL_STOP_EN
                else if (w_mismatch) begin
                    w_next_state = c_st_done;
                end
`endif
                else begin
                    w_next_state = c_st_settle;
                end
            end
            c_st_done: begin
                if (start) w_next_state = c_st_settle;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Vector index, settle counter and result bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index      <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_err_count  <= 5'd0;
            r_first_fail <= 4'd0;
            r_fail_valid <= 1'b0;
        end else if (w_start_ok) begin
            r_index      <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_err_count  <= 5'd0;
            r_first_fail <= 4'd0;
            r_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_settle: begin
                    if (!w_settle_end) r_settle_cnt <= r_settle_cnt + 4'd1;
                end
                c_st_sample: begin
                    if (w_mismatch) begin
                        // 16 vectors bound the count, the guard just keeps it from wrapping
                        if (r_err_count != c_err_max) r_err_count <= r_err_count + 5'd1;
                        if (!r_fail_valid) begin
                            r_first_fail <= r_index;
                            r_fail_valid <= 1'b1;
                        end
                    end
                    if (w_next_state == c_st_settle) begin
                        r_index      <= r_index + 4'd1;
                        r_settle_cnt <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and bookkeeping registers
    always_comb begin
        busy         = (r_state == c_st_settle) || (r_state == c_st_sample);
        done         = (r_state == c_st_done);
        {a, b, c, d} = busy ? r_index : 4'd0;
        pass         = done && (r_err_count == 5'd0);
        err_count    = r_err_count;
        first_fail   = r_first_fail;
        fail_valid   = r_fail_valid;
    end

endmodule
`default_nettype wire

// File: doc/function_checker.md
FUNCTION_CHECKER -- requirements
Module: function_checker

Interface
REQ-001 The block SHALL have parameter EXPECTED, default 16'hF888; golden truth table, bit n = required f for vector n.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15; cycles each vector is held before f is sampled.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to run a full check.
REQ-006 The block SHALL have ports a, b, c, d, each output, 1 bit: stimulus to the function under test; a is MSB, {a,b,c,d} = vector index.
REQ-007 The block SHALL have port f, input, 1 bit: response of the function under test.
REQ-008 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a run has completed, held until the next start or reset.
REQ-010 The block SHALL have port pass, output, 1 bit: done and zero mismatches.
REQ-011 The block SHALL have port err_count, output, 5 bits: number of mismatching vectors, 0..16.
REQ-012 The block SHALL have port first_fail, output, 4 bits: index of the first mismatching vector.
REQ-013 The block SHALL have port fail_valid, output, 1 bit: first_fail holds a valid index.

Function
REQ-014 The block SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 start in IDLE or DONE SHALL, at that edge: go to SETTLE; index=0; settle count=0; err_count=0; fail_valid=0; first_fail=0; done=0.
REQ-016 start in SETTLE or SAMPLE SHALL be ignored.
REQ-017 SETTLE SHALL count SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-018 {a,b,c,d} SHALL be driven from the registered index during SETTLE and SAMPLE, and SHALL be 4'b0000 in IDLE and DONE.
REQ-019 At the SAMPLE edge, f SHALL be compared with EXPECTED[index]; on mismatch, err_count increments, and if fail_valid=0, first_fail=index and fail_valid=1.
REQ-020 SAMPLE with index<15 SHALL go to SETTLE with index+1 and the settle count cleared; SAMPLE with index=15 SHALL go to DONE.
REQ-021 Each vector SHALL take SETTLE_CYCLES+1 cycles; a full run SHALL take 16*(SETTLE_CYCLES+1) cycles from the start edge to done=1.
REQ-022 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-023 pass SHALL equal done AND (err_count==0).
REQ-024 err_count SHALL reach 16 without wrapping.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force state=IDLE, index=0, settle count=0, and all outputs 0: a, b, c, d, busy, done, pass, err_count, first_fail, fail_valid.
REQ-026 Reset asserted mid-run SHALL abandon the run with no partial results retained.
REQ-027 After rst_n rises, the block SHALL remain in IDLE until start.

Configuration
REQ-028 When macro FUNCTION_CHECKER_FAIL_STOP_EN is defined, the first mismatch at SAMPLE SHALL transition to DONE at that edge, giving err_count=1.
REQ-029 When FUNCTION_CHECKER_FAIL_STOP_EN is undefined, all 16 vectors SHALL always be checked.

Verification
REQ-030 Reset check: drive rst_n=0 mid-clock -> all outputs 0 without waiting for a clk edge.
REQ-031 Correct run: DUT f=(a&b)|(c&d), defaults, one start pulse -> done=1 exactly 48 cycles later, err_count=0, pass=1, fail_valid=0.
REQ-032 Stuck-at-0 run: f tied to 0, macro undefined -> err_count=7, first_fail=3, fail_valid=1, pass=0.
REQ-033 Fail-stop run: f tied to 0, macro defined -> done=1 after 12 cycles, err_count=1, first_fail=3, {a,b,c,d}=0 in DONE.
REQ-034 Reset mid-run: rst_n=0 while index=8 -> IDLE with all outputs 0; a subsequent start completes the correct run with pass=1.
REQ-035 start handling: start pulsed at index=5 -> no effect, done after 48 cycles; start in DONE -> done=0 and err_count=0 on the next cycle, and a new run begins.
